// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ALUOp encodings, the ID/EX control bundle and the
// hazard-stall FSM state.
package pipeline_pkg;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: the ID instruction reads the register that the
// load currently in EX is about to write.
module load_use_detect (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_reg_dst_i,
  input  logic       id_mem_write_i,
  input  logic       id_branch_i,
  output logic       haz_o
);

  logic rt_used;

  // rt is a source for R-type, store data and branch compare; $0 never hazards.
  assign rt_used = id_reg_dst_i | id_mem_write_i | id_branch_i;
  assign haz_o   = ex_mem_read_i & (ex_rt_i != 5'd0) &
                   ((ex_rt_i == id_rs_i) | (rt_used & (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall FSM, flush bubbles and a
// saturating count of hazard-stall cycles.
module id_ex_hazard_stage
  import pipeline_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_reg_dst,
  input  logic                   id_alu_src,
  input  logic                   id_mem_to_reg,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_mem_write,
  input  logic                   id_branch,
  input  logic [1:0]             id_alu_op,
  input  logic [31:0]            id_pc_plus4,
  input  logic [31:0]            id_rd_data1,
  input  logic [31:0]            id_rd_data2,
  input  logic [31:0]            id_imm,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic [4:0]             id_rd,
  input  logic [5:0]             id_funct,
  input  logic                   flush,
  output logic                   ex_reg_dst,
  output logic                   ex_alu_src,
  output logic                   ex_mem_to_reg,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic                   ex_branch,
  output logic [1:0]             ex_alu_op,
  output logic [31:0]            ex_pc_plus4,
  output logic [31:0]            ex_rd_data1,
  output logic [31:0]            ex_rd_data2,
  output logic [31:0]            ex_imm,
  output logic [4:0]             ex_rs,
  output logic [4:0]             ex_rt,
  output logic [4:0]             ex_rd,
  output logic [5:0]             ex_funct,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  ctrl_t                  id_ctrl, ctrl_d, ctrl_q;
  state_e                 state_d, state_q;
  logic [1:0]             cnt_d, cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [31:0]            pc_plus4_q, rd_data1_q, rd_data2_q, imm_q;
  logic [4:0]             rs_q, rt_q, rd_q;
  logic [5:0]             funct_q;
  logic                   haz;

  assign id_ctrl = '{reg_dst: id_reg_dst, alu_src: id_alu_src, mem_to_reg: id_mem_to_reg,
                     reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                     branch: id_branch, alu_op: id_alu_op};

  load_use_detect u_detect (
    .ex_mem_read_i  (ctrl_q.mem_read),
    .ex_rt_i        (rt_q),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_reg_dst_i   (id_reg_dst),
    .id_mem_write_i (id_mem_write),
    .id_branch_i    (id_branch),
    .haz_o          (haz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  // Flush outranks the hazard; both load a bubble instead of the ID control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = id_ctrl;
    case (state_q)
      RUN: begin
        if (flush) begin
          ctrl_d = CTRL_NOP;
        end else if (haz) begin
          ctrl_d = CTRL_NOP;
          cnt_d  = BUB_INIT;
          if (BUB_INIT != 2'd0) state_d = STALL;
        end
      end
      STALL: begin
        ctrl_d = CTRL_NOP;
        if (flush) begin
          cnt_d   = 2'd0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall       = ~flush & (haz | (state_q == STALL));
    pc_write    = ~stall;
    if_id_write = ~stall;
  end

  // ID -> EX register; datapath fields load even under a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_NOP;
      pc_plus4_q <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_plus4_q <= id_pc_plus4;
      rd_data1_q <= id_rd_data1;
      rd_data2_q <= id_rd_data2;
      imm_q      <= id_imm;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      rd_q       <= id_rd;
      funct_q    <= id_funct;
    end
  end

  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_branch     = ctrl_q.branch;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_pc_plus4   = pc_plus4_q;
  assign ex_rd_data1   = rd_data1_q;
  assign ex_rd_data2   = rd_data2_q;
  assign ex_imm        = imm_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_funct      = funct_q;
  assign stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: three instances (1 bubble, 3 bubbles,
// 4-bit stall counter) share one ID stimulus stream.
module tb_id_ex_hazard_stage;
  import pipeline_pkg::*;

  typedef struct packed {
    logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0] alu_op;
    logic [31:0] pc4, d1, d2, imm;
    logic [4:0] rs, rt, rd;
    logic [5:0] funct;
    logic pc_write, if_id_write, stall;
  } out_t;

  localparam logic [8:0] C_RTYPE = {7'b1001000, ALUOP_RTYPE};
  localparam logic [8:0] C_LW    = {7'b0111100, ALUOP_MEM};
  localparam logic [8:0] C_ADDI  = {7'b0101000, ALUOP_IMM};
  localparam logic [8:0] C_SW    = {7'b0100010, ALUOP_MEM};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, flush;
  logic [1:0] alu_op;
  logic [31:0] pc4, d1, d2, imm;
  logic [4:0] rs, rt, rd;
  logic [5:0] funct;
  out_t o1, o3, os;
  logic [15:0] sc1, sc3;
  logic [3:0] scs;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`define DUT_CONN(O, SC) \
    .clk(clk), .rst_n(rst_n), .id_reg_dst(reg_dst), .id_alu_src(alu_src), \
    .id_mem_to_reg(mem_to_reg), .id_reg_write(reg_write), .id_mem_read(mem_read), \
    .id_mem_write(mem_write), .id_branch(branch), .id_alu_op(alu_op), .id_pc_plus4(pc4), \
    .id_rd_data1(d1), .id_rd_data2(d2), .id_imm(imm), .id_rs(rs), .id_rt(rt), .id_rd(rd), \
    .id_funct(funct), .flush(flush), .ex_reg_dst(O.reg_dst), .ex_alu_src(O.alu_src), \
    .ex_mem_to_reg(O.mem_to_reg), .ex_reg_write(O.reg_write), .ex_mem_read(O.mem_read), \
    .ex_mem_write(O.mem_write), .ex_branch(O.branch), .ex_alu_op(O.alu_op), \
    .ex_pc_plus4(O.pc4), .ex_rd_data1(O.d1), .ex_rd_data2(O.d2), .ex_imm(O.imm), \
    .ex_rs(O.rs), .ex_rt(O.rt), .ex_rd(O.rd), .ex_funct(O.funct), .pc_write(O.pc_write), \
    .if_id_write(O.if_id_write), .stall(O.stall), .stall_cycles(SC)

  id_ex_hazard_stage #(.LOAD_BUBBLES(1), .STALL_CNT_W(16)) u_b1 (`DUT_CONN(o1, sc1));
  id_ex_hazard_stage #(.LOAD_BUBBLES(3), .STALL_CNT_W(16)) u_b3 (`DUT_CONN(o3, sc3));
  id_ex_hazard_stage #(.LOAD_BUBBLES(1), .STALL_CNT_W(4))  u_sat (`DUT_CONN(os, scs));
`undef DUT_CONN

  function automatic logic [8:0] ctrl_of(input out_t o);
    return {o.reg_dst, o.alu_src, o.mem_to_reg, o.reg_write, o.mem_read, o.mem_write, o.branch, o.alu_op};
  endfunction

  task automatic set_id(input logic [8:0] c, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op} = c;
    rs = s; rt = t; rd = d;
    pc4 = pc4 + 32'd4;
    d1 = 32'hA000_0000 | {27'd0, s};
    d2 = 32'hB000_0000 | {27'd0, t};
    imm = {27'd0, d};
    funct = 6'h20;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b0;
    pc4 = 32'h0000_0100;
    set_id(9'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    flush = 1'b0;
    pc4 = 32'h0000_0100;
    set_id(C_RTYPE, 5'd3, 5'd4, 5'd5);
    step(); step();
    n_checks++; if (ctrl_of(o1) !== 9'd0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", ctrl_of(o1)); end
    n_checks++; if (o1.rd !== 5'd0 || o1.pc4 !== 32'd0 || o1.d1 !== 32'd0) begin n_fail++; $display("FAIL reset_data: rd=%0d pc4=%h d1=%h want 0", o1.rd, o1.pc4, o1.d1); end
    n_checks++; if (o1.pc_write !== 1'b1 || o1.if_id_write !== 1'b1 || o1.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: pcw=%b ifw=%b stall=%b want 1 1 0", o1.pc_write, o1.if_id_write, o1.stall); end
    n_checks++; if (sc1 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", sc1); end
  endtask

  task automatic test_rtype();
    do_reset();
    pc4 = 32'h0000_0100;
    set_id(C_RTYPE, 5'd3, 5'd4, 5'd5);
    #1;
    n_checks++; if (o1.pc_write !== 1'b1) begin n_fail++; $display("FAIL rtype_pcw_pre: got %b want 1", o1.pc_write); end
    step();
    n_checks++; if (ctrl_of(o1) !== C_RTYPE) begin n_fail++; $display("FAIL rtype_ctrl: got %b want %b", ctrl_of(o1), C_RTYPE); end
    n_checks++; if (o1.rd !== 5'd5 || o1.rs !== 5'd3 || o1.rt !== 5'd4) begin n_fail++; $display("FAIL rtype_regs: rs=%0d rt=%0d rd=%0d want 3 4 5", o1.rs, o1.rt, o1.rd); end
    n_checks++; if (o1.pc4 !== 32'h104 || o1.d1 !== 32'hA000_0003 || o1.funct !== 6'h20) begin n_fail++; $display("FAIL rtype_data: pc4=%h d1=%h funct=%h want 104 a0000003 20", o1.pc4, o1.d1, o1.funct); end
    n_checks++; if (o1.pc_write !== 1'b1) begin n_fail++; $display("FAIL rtype_pcw: got %b want 1", o1.pc_write); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(C_LW, 5'd1, 5'd8, 5'd0);
    step();
    n_checks++; if (o1.mem_read !== 1'b1 || o1.rt !== 5'd8) begin n_fail++; $display("FAIL lu_lw_ex: mem_read=%b rt=%0d want 1 8", o1.mem_read, o1.rt); end
    set_id(C_RTYPE, 5'd8, 5'd2, 5'd3);
    #1;
    n_checks++; if (o1.stall !== 1'b1 || o1.pc_write !== 1'b0 || o1.if_id_write !== 1'b0) begin n_fail++; $display("FAIL lu_stall: stall=%b pcw=%b ifw=%b want 1 0 0", o1.stall, o1.pc_write, o1.if_id_write); end
    step();
    n_checks++; if (ctrl_of(o1) !== 9'd0) begin n_fail++; $display("FAIL lu_bubble: got %b want 0", ctrl_of(o1)); end
    n_checks++; if (o1.stall !== 1'b0 || o1.pc_write !== 1'b1 || sc1 !== 16'd1) begin n_fail++; $display("FAIL lu_release: stall=%b pcw=%b cnt=%0d want 0 1 1", o1.stall, o1.pc_write, sc1); end
    step();
    n_checks++; if (ctrl_of(o1) !== C_RTYPE || o1.rd !== 5'd3 || sc1 !== 16'd1) begin n_fail++; $display("FAIL lu_add_enters: ctrl=%b rd=%0d cnt=%0d want %b 3 1", ctrl_of(o1), o1.rd, sc1, C_RTYPE); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_id(C_LW, 5'd1, 5'd0, 5'd0);
    step();
    set_id(C_RTYPE, 5'd0, 5'd0, 5'd6);
    #1;
    n_checks++; if (o1.stall !== 1'b0 || o1.pc_write !== 1'b1) begin n_fail++; $display("FAIL zero_nostall: stall=%b pcw=%b want 0 1", o1.stall, o1.pc_write); end
    step();
    n_checks++; if (ctrl_of(o1) !== C_RTYPE || sc1 !== 16'd0) begin n_fail++; $display("FAIL zero_pass: ctrl=%b cnt=%0d want %b 0", ctrl_of(o1), sc1, C_RTYPE); end
  endtask

  task automatic test_rt_used();
    do_reset();
    set_id(C_LW, 5'd1, 5'd9, 5'd0);
    step();
    set_id(C_ADDI, 5'd2, 5'd9, 5'd0);
    #1;
    n_checks++; if (o1.stall !== 1'b0) begin n_fail++; $display("FAIL addi_nostall: got %b want 0", o1.stall); end
    step();
    n_checks++; if (ctrl_of(o1) !== C_ADDI) begin n_fail++; $display("FAIL addi_pass: got %b want %b", ctrl_of(o1), C_ADDI); end
    set_id(C_LW, 5'd1, 5'd9, 5'd0);
    step();
    set_id(C_SW, 5'd2, 5'd9, 5'd0);
    #1;
    n_checks++; if (o1.stall !== 1'b1 || o1.pc_write !== 1'b0) begin n_fail++; $display("FAIL sw_stall: stall=%b pcw=%b want 1 0", o1.stall, o1.pc_write); end
    step();
    n_checks++; if (ctrl_of(o1) !== 9'd0 || sc1 !== 16'd1) begin n_fail++; $display("FAIL sw_bubble: ctrl=%b cnt=%0d want 0 1", ctrl_of(o1), sc1); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(C_RTYPE, 5'd3, 5'd4, 5'd5);
    flush = 1'b1;
    #1;
    n_checks++; if (o1.pc_write !== 1'b1 || o1.stall !== 1'b0) begin n_fail++; $display("FAIL flush_pcw: pcw=%b stall=%b want 1 0", o1.pc_write, o1.stall); end
    step();
    n_checks++; if (ctrl_of(o1) !== 9'd0 || o1.rd !== 5'd5) begin n_fail++; $display("FAIL flush_bubble: ctrl=%b rd=%0d want 0 5", ctrl_of(o1), o1.rd); end
    flush = 1'b0;
    set_id(C_LW, 5'd1, 5'd8, 5'd0);
    step();
    set_id(C_RTYPE, 5'd8, 5'd2, 5'd3);
    flush = 1'b1;
    #1;
    n_checks++; if (o1.stall !== 1'b0 || o1.pc_write !== 1'b1) begin n_fail++; $display("FAIL flush_over_haz: stall=%b pcw=%b want 0 1", o1.stall, o1.pc_write); end
    step();
    flush = 1'b0;
    n_checks++; if (ctrl_of(o1) !== 9'd0 || sc1 !== 16'd0) begin n_fail++; $display("FAIL flush_haz_cnt: ctrl=%b cnt=%0d want 0 0", ctrl_of(o1), sc1); end
  endtask

  task automatic test_multi_bubble();
    do_reset();
    set_id(C_LW, 5'd1, 5'd8, 5'd0);
    step();
    set_id(C_RTYPE, 5'd8, 5'd2, 5'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (o3.stall !== 1'b1 || o3.pc_write !== 1'b0) begin n_fail++; $display("FAIL mb_stall%0d: stall=%b pcw=%b want 1 0", i, o3.stall, o3.pc_write); end
      step();
      n_checks++; if (ctrl_of(o3) !== 9'd0) begin n_fail++; $display("FAIL mb_bubble%0d: got %b want 0", i, ctrl_of(o3)); end
    end
    n_checks++; if (o3.stall !== 1'b0 || sc3 !== 16'd3) begin n_fail++; $display("FAIL mb_done: stall=%b cnt=%0d want 0 3", o3.stall, sc3); end
    step();
    n_checks++; if (ctrl_of(o3) !== C_RTYPE) begin n_fail++; $display("FAIL mb_add_enters: got %b want %b", ctrl_of(o3), C_RTYPE); end
    do_reset();
    set_id(C_LW, 5'd1, 5'd8, 5'd0);
    step();
    set_id(C_RTYPE, 5'd8, 5'd2, 5'd3);
    step();
    n_checks++; if (o3.stall !== 1'b1 || sc3 !== 16'd1) begin n_fail++; $display("FAIL mb_in_stall: stall=%b cnt=%0d want 1 1", o3.stall, sc3); end
    flush = 1'b1;
    #1;
    n_checks++; if (o3.stall !== 1'b0 || o3.pc_write !== 1'b1) begin n_fail++; $display("FAIL mb_flush_stall: stall=%b pcw=%b want 0 1", o3.stall, o3.pc_write); end
    step();
    flush = 1'b0;
    #1;
    n_checks++; if (ctrl_of(o3) !== 9'd0 || o3.stall !== 1'b0 || sc3 !== 16'd1) begin n_fail++; $display("FAIL mb_flush_abort: ctrl=%b stall=%b cnt=%0d want 0 0 1", ctrl_of(o3), o3.stall, sc3); end
    step();
    n_checks++; if (ctrl_of(o3) !== C_RTYPE || sc3 !== 16'd1) begin n_fail++; $display("FAIL mb_flush_run: ctrl=%b cnt=%0d want %b 1", ctrl_of(o3), sc3, C_RTYPE); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_id(C_LW, 5'd1, 5'd8, 5'd0);
      step();
      set_id(C_RTYPE, 5'd8, 5'd2, 5'd3);
      step();
      if (i == 14) begin
        n_checks++; if (scs !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", scs); end
      end
    end
    n_checks++; if (scs !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", scs); end
    set_id(C_LW, 5'd1, 5'd8, 5'd0);
    step();
    set_id(C_RTYPE, 5'd8, 5'd2, 5'd3);
    #2;
    n_checks++; if (os.stall !== 1'b1) begin n_fail++; $display("FAIL sat_prestall: got %b want 1", os.stall); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ctrl_of(os) !== 9'd0 || os.rt !== 5'd0 || os.pc4 !== 32'd0) begin n_fail++; $display("FAIL async_rst_ex: ctrl=%b rt=%0d pc4=%h want 0", ctrl_of(os), os.rt, os.pc4); end
    n_checks++; if (os.pc_write !== 1'b1 || os.stall !== 1'b0 || scs !== 4'd0) begin n_fail++; $display("FAIL async_rst_ctl: pcw=%b stall=%b cnt=%0d want 1 0 0", os.pc_write, os.stall, scs); end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_zero_reg();
    test_rt_used();
    test_flush();
    test_multi_bubble();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
